nios2_key_event_ctrl: RTL and testbench
=======================================

# nios2_key_event_ctrl

Avalon-MM master that services the 4-bit key PIO slave. Programs the PIO interrupt mask, answers its `irq` by reading and clearing the edge-capture register, and waits a debounce hold-off before re-reading the key levels. It then pushes confirmed key-press events into a small FIFO with a valid/ready consumer port. It sits between the key PIO and fabric logic (LED/menu control) that needs debounced key events without Nios II software involvement.

## Interface
- `KEY_W`, 4, number of keys; matches PIO width.
- `IRQ_MASK`, 4'hF, value written to PIO irq-mask register after reset.
- `HOLDOFF`, 50000, debounce wait in clk cycles; legal range 1..65535.
- `FIFO_DEPTH`, 4, event FIFO entries; power of two.

- `clk`  in  1  single clock, shared with the PIO.
- `reset`  in  1  synchronous, active-high.
- `avm_address`  out  2  PIO register offset.
- `avm_chipselect`  out  1  PIO select.
- `avm_write_n`  out  1  active-low write strobe.
- `avm_writedata`  out  32  write data.
- `avm_readdata`  in  32  PIO read data; registered in the PIO, valid one cycle after address.
- `pio_irq`  in  1  PIO interrupt.
- `enable`  in  1  allows new service sequences.
- `evt_valid`  out  1  FIFO non-empty.
- `evt_ready`  in  1  consumer pop.
- `evt_data`  out  2*KEY_W  {confirmed_mask, level_snapshot}; head entry.
- `overflow`  out  1  sticky: confirmed event dropped because FIFO was full.
- `overflow_clr`  in  1  clears `overflow`.
- `busy`  out  1  state != IDLE.

## Operation
- FSM states:
  - INIT: write `IRQ_MASK` to offset 2 (1 cycle) -> IDLE.
  - IDLE: if `enable && pio_irq` -> RD_EC.
  - RD_EC: address 3, read -> CAP_EC.
  - CAP_EC: latch `ec = avm_readdata[KEY_W-1:0]`; issue clear write (address 3, writedata 0); `ec==0` -> IDLE, else -> HOLD.
  - HOLD: count exactly `HOLDOFF` cycles -> RD_DATA.
  - RD_DATA: address 0, read -> CAP_DATA.
  - CAP_DATA: `level = avm_readdata[KEY_W-1:0]`, `confirmed = ec & ~level` (keys active-low; press = falling edge); push {confirmed, level} if `confirmed != 0` -> IDLE.
- Bus idle values: address 0, chipselect 0, write_n 1, writedata 0. Writes are single-cycle (chipselect=1, write_n=0). Reads use write_n=1; chipselect is asserted.
- Push while full: entry dropped, `overflow` set. A push is accepted if `!full || pop` in the same cycle.
- `overflow`: set wins over a simultaneous `overflow_clr`.
- `enable` is sampled only in IDLE. Deasserting it never aborts a sequence in progress.
- Edges that arrive at the PIO in the CAP_EC cycle are lost, because the PIO clear has priority. This is an accepted limit; the clear write therefore issues in the same cycle as the capture.
- Bounces during HOLD re-set PIO edge-capture and cause one extra sequence. That sequence confirms nothing when the key is stable-released.

## Timing
- Reset (`reset` high at a clk edge): state=INIT, FIFO emptied, `overflow`=0, `evt_valid`=0, `busy`=1, bus at idle values. A reset mid-sequence aborts the sequence; the mask is rewritten on exit.
- INIT occupies the first cycle after reset release.
- With `pio_irq` seen in IDLE at cycle 0:
  - RD_EC at c1, CAP_EC/clear at c2.
  - HOLD at c3..c(HOLDOFF+2).
  - RD_DATA at c(HOLDOFF+3), CAP_DATA at c(HOLDOFF+4).
  - `evt_valid` high at c(HOLDOFF+5).
- `evt_data` is stable while `evt_valid && !evt_ready`. Pop takes effect at the edge where both are high.
- Hold-off counter: 16-bit, loaded with `HOLDOFF-1`, down-counts to 0.

## Structure
- Package `nios2_key_pkg`:
  - state enum;
  - PIO offsets `PIO_DATA=0`, `PIO_IRQMASK=2`, `PIO_EDGECAP=3`;
  - event struct {confirmed, level}.
- Sub-module `nios2_key_evt_fifo`: synchronous FIFO, parameterised width/depth, with full/empty outputs.

## Test plan
- Reset release -> one write cycle: address 2, writedata 0xF. Then bus idle, `busy`=0.
- PIO model sets edge-capture 0x1, irq high, data reads 0xE after hold-off (HOLDOFF=8) -> clear write at c2, `evt_data`=0x1E, `evt_valid` at c13.
- Edge-capture 0x3, key 1 released before RD_DATA (data 0xE) -> `evt_data`=0x1E: key 1 rejected.
- Spurious irq with edge-capture 0 -> return to IDLE at c3, no push.
- Five confirmed events with `evt_ready`=0 -> four entries held, `overflow`=1. Pop one and push in the same cycle -> accepted. `overflow_clr` with a simultaneous drop -> `overflow` stays 1.
- Assert `reset` during HOLD -> FIFO empty, INIT mask write repeated, no event produced.

Source files
------------

// File: rtl/nios2_key_pkg.sv
// Shared definitions for the key-event controller.
//   state_t     : controller FSM states
//   PIO_*       : register offsets of the key PIO slave
//   key_evt_t   : event record {confirmed, level} at the default 4-key width
package nios2_key_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_EC,
    ST_CAP_EC,
    ST_HOLD,
    ST_RD_DATA,
    ST_CAP_DATA
  } state_t;

  localparam logic [1:0] PIO_DATA    = 2'd0;
  localparam logic [1:0] PIO_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_EDGECAP = 2'd3;

  localparam int EVT_KEY_W = 4;

  typedef struct packed {
    logic [EVT_KEY_W-1:0] confirmed;
    logic [EVT_KEY_W-1:0] level;
  } key_evt_t;

endpackage

// File: rtl/nios2_key_event_ctrl_if.sv
// Avalon-MM bus between the key-event controller (master) and the key PIO
// (slave).
//   avm_address    : PIO register offset
//   avm_chipselect : PIO select
//   avm_write_n    : active-low write strobe
//   avm_writedata  : write data
//   avm_readdata   : read data, registered in the PIO (one cycle after address)
interface nios2_key_event_ctrl_if;

  logic [1:0]  avm_address;
  logic        avm_chipselect;
  logic        avm_write_n;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_chipselect,
    output avm_write_n,
    output avm_writedata,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_chipselect,
    input  avm_write_n,
    input  avm_writedata,
    output avm_readdata
  );

endinterface

// File: rtl/nios2_key_evt_fifo.sv
// Synchronous FIFO holding confirmed key events.
//   clk, reset : clock, synchronous active-high reset (empties the FIFO)
//   wr_en      : push request; accepted when not full or when popping too
//   wr_data    : entry to push
//   rd_en      : pop request; ignored when empty
//   rd_data    : head entry
//   full/empty : occupancy flags
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module nios2_key_evt_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  assign do_rd = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/nios2_key_event_ctrl.sv
// Key PIO service engine: programs the PIO irq mask, answers pio_irq by
// reading and clearing edge-capture, waits a debounce hold-off, re-reads the
// key levels and queues confirmed presses (falling edges still low).
//   clk, reset       : clock shared with the PIO, synchronous active-high reset
//   avm              : Avalon-MM master port to the key PIO
//   pio_irq          : PIO interrupt
//   enable           : allows new service sequences (sampled in IDLE only)
//   evt_valid/ready  : event consumer handshake, evt_data = {confirmed, level}
//   overflow         : sticky, a confirmed event was dropped (FIFO full)
//   overflow_clr     : clears overflow; a simultaneous drop wins
//   busy             : controller is not idle
//
// state       | meaning
// ST_INIT     | write IRQ_MASK to the PIO mask register, then idle
// ST_IDLE     | wait for enable && pio_irq
// ST_RD_EC    | read address: edge-capture
// ST_CAP_EC   | edge-capture data on the bus; clear write issued this cycle
// ST_HOLD     | debounce hold-off, HOLDOFF cycles
// ST_RD_DATA  | read address: key levels
// ST_CAP_DATA | level data on the bus; push confirmed event
module nios2_key_event_ctrl
  import nios2_key_pkg::*;
#(
  parameter int               KEY_W      = 4,
  parameter logic [KEY_W-1:0] IRQ_MASK   = {KEY_W{1'b1}},
  parameter int               HOLDOFF    = 50000,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  nios2_key_event_ctrl_if.master avm,
  input  logic                 pio_irq,
  input  logic                 enable,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [2*KEY_W-1:0]   evt_data,
  output logic                 overflow,
  input  logic                 overflow_clr,
  output logic                 busy
);

  typedef struct packed {
    logic [KEY_W-1:0] confirmed;
    logic [KEY_W-1:0] level;
  } evt_t;

  localparam logic [15:0] HOLD_LOAD = 16'(HOLDOFF - 1);

  state_t           state;
  logic [1:0]       address_q;
  logic             chipselect_q;
  logic             write_n_q;
  logic [31:0]      writedata_q;
  logic [KEY_W-1:0] ec_q;
  logic [15:0]      hold_cnt;

  logic [KEY_W-1:0] rd_keys;
  logic [KEY_W-1:0] confirmed;
  evt_t             push_evt;
  logic             push_req;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_rd_hi;

  assign rd_keys      = avm.avm_readdata[KEY_W-1:0];
  assign unused_rd_hi = ^avm.avm_readdata[31:KEY_W];

  // Keys are active-low: a press is a captured edge whose level is still low.
  assign confirmed = ec_q & ~rd_keys;
  assign push_req  = (state == ST_CAP_DATA) && (confirmed != '0);
  assign push_evt  = '{confirmed: confirmed, level: rd_keys};

  // Bus outputs are registered and loaded on entry to the state that owns
  // the bus cycle, so the PIO sees them during that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_INIT;
      address_q    <= PIO_DATA;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      writedata_q  <= '0;
      ec_q         <= '0;
      hold_cnt     <= '0;
    end else begin
      address_q    <= PIO_DATA;
      chipselect_q <= 1'b0;
      write_n_q    <= 1'b1;
      writedata_q  <= '0;
      case (state)
        ST_INIT: begin
          // First cycle out of reset drives the mask write; the next leaves.
          if (write_n_q) begin
            address_q    <= PIO_IRQMASK;
            chipselect_q <= 1'b1;
            write_n_q    <= 1'b0;
            writedata_q  <= 32'(IRQ_MASK);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (enable && pio_irq) begin
            state        <= ST_RD_EC;
            address_q    <= PIO_EDGECAP;
            chipselect_q <= 1'b1;
          end
        end
        ST_RD_EC: begin
          // Clear write goes out in the capture cycle; readdata still
          // carries the edge-capture value read in this cycle.
          state        <= ST_CAP_EC;
          address_q    <= PIO_EDGECAP;
          chipselect_q <= 1'b1;
          write_n_q    <= 1'b0;
        end
        ST_CAP_EC: begin
          ec_q <= rd_keys;
          if (rd_keys == '0) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_HOLD;
            hold_cnt <= HOLD_LOAD;
          end
        end
        ST_HOLD: begin
          if (hold_cnt == '0) begin
            state        <= ST_RD_DATA;
            address_q    <= PIO_DATA;
            chipselect_q <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        ST_RD_DATA:  state <= ST_CAP_DATA;
        ST_CAP_DATA: state <= ST_IDLE;
        default:     state <= ST_INIT;
      endcase
    end
  end

  assign pop  = evt_ready && !fifo_empty;
  assign drop = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  nios2_key_evt_fifo #(
    .WIDTH (2*KEY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (push_req),
    .wr_data (push_evt),
    .rd_en   (evt_ready),
    .rd_data (evt_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign busy      = (state != ST_IDLE);

  assign avm.avm_address    = address_q;
  assign avm.avm_chipselect = chipselect_q;
  assign avm.avm_write_n    = write_n_q;
  assign avm.avm_writedata  = writedata_q;

endmodule

// File: tb/tb_nios2_key_event_ctrl.sv
module tb_nios2_key_event_ctrl;

  localparam int H     = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pio_irq;
  logic       enable;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_data;
  logic       overflow;
  logic       overflow_clr;
  logic       busy;

  nios2_key_event_ctrl_if avm ();

  // PIO slave model: edge-capture set directly by the bench, clear on write.
  logic [3:0]  pio_ec      = 4'h0;
  logic [3:0]  pio_mask    = 4'h0;
  logic [3:0]  pio_lvl     = 4'hF;
  logic [3:0]  ec_set      = 4'h0;
  logic        irq_force   = 1'b0;
  logic [31:0] rd_q        = 32'h0;
  int          mask_wr_cnt = 0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];
  logic       exp_ovf;

  always #5 clk = ~clk;

  assign avm.avm_readdata = rd_q;
  assign pio_irq = (|(pio_ec & pio_mask)) | irq_force;

  always @(posedge clk) begin
    case (avm.avm_address)
      2'd0:    rd_q <= {28'd0, pio_lvl};
      2'd2:    rd_q <= {28'd0, pio_mask};
      2'd3:    rd_q <= {28'd0, pio_ec};
      default: rd_q <= 32'd0;
    endcase
    if (avm.avm_chipselect && !avm.avm_write_n && avm.avm_address == 2'd3)
      pio_ec <= 4'h0;
    else
      pio_ec <= pio_ec | ec_set;
    if (avm.avm_chipselect && !avm.avm_write_n && avm.avm_address == 2'd2) begin
      pio_mask    <= avm.avm_writedata[3:0];
      mask_wr_cnt <= mask_wr_cnt + 1;
    end
  end

  nios2_key_event_ctrl #(
    .KEY_W      (4),
    .IRQ_MASK   (4'hF),
    .HOLDOFF    (H),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .avm          (avm.master),
    .pio_irq      (pio_irq),
    .enable       (enable),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .busy         (busy)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_fifo_view(input string tag);
    chk({tag, "_valid"}, evt_valid, exp_q.size() != 0);
    chk({tag, "_ovf"}, overflow, exp_ovf);
    if (exp_q.size() != 0) chk({tag, "_head"}, evt_data, exp_q[0]);
  endtask

  // Starts at a negedge; pops everything and checks each entry in order.
  task automatic drain();
    int n = 0;
    while (evt_valid && n < 2*DEPTH) begin
      if (exp_q.size() == 0) chk("drain_extra", evt_data, 8'hxx);
      else chk("drain_data", evt_data, exp_q.pop_front());
      evt_ready = 1'b1;
      @(negedge clk);
      evt_ready = 1'b0;
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  // One service sequence. k counts cycles from the IDLE cycle that sees irq.
  // ec == 0 makes a spurious irq pulse instead.
  task automatic run_seq(input logic [3:0] ec, input logic [3:0] lvl,
                         input int pop_k, input int clr_k, output int vr_at);
    int   clr_at = -1;
    int   rd_at  = -1;
    int   idle_at = -1;
    logic seen_busy = 1'b0;
    logic prev_v;
    logic [3:0] conf;
    logic dropped = 1'b0;
    vr_at   = -1;
    pio_lvl = lvl;
    ec_set  = ec;
    @(negedge clk);
    ec_set    = 4'h0;
    irq_force = (ec == 4'h0);
    prev_v    = evt_valid;
    for (int k = 0; k < 60; k++) begin
      if (k == 1) irq_force = 1'b0;
      if (avm.avm_chipselect && !avm.avm_write_n && avm.avm_address == 2'd3 && clr_at < 0) begin
        clr_at = k;
        chk("clr_wdata", avm.avm_writedata, 32'h0);
      end
      if (avm.avm_chipselect && avm.avm_write_n && avm.avm_address == 2'd0 && rd_at < 0) rd_at = k;
      if (!prev_v && evt_valid && vr_at < 0) vr_at = k;
      prev_v = evt_valid;
      if (busy) seen_busy = 1'b1;
      else if (seen_busy) begin
        idle_at = k;
        break;
      end
      evt_ready    = (k == pop_k);
      overflow_clr = (k == clr_k);
      if (k == pop_k) chk("pop_head", evt_data, exp_q.pop_front());
      @(negedge clk);
    end
    evt_ready    = 1'b0;
    overflow_clr = 1'b0;
    chk("seq_idle_cycle", idle_at, (ec == 4'h0) ? 3 : H + 5);
    chk("seq_clr_cycle", clr_at, 2);
    chk("seq_rd_cycle", rd_at, (ec == 4'h0) ? -1 : H + 3);
    conf = ec & ~lvl;
    if (conf != 4'h0) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({conf, lvl});
      else dropped = 1'b1;
    end
    if (dropped) exp_ovf = 1'b1;
    else if (clr_k >= 0) exp_ovf = 1'b0;
    check_fifo_view("seq");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int vr;
    int m0;
    logic [3:0] rec, rlv;
    int pk, ck;
    reset = 1'b1; enable = 1'b1; evt_ready = 1'b0; overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs", avm.avm_chipselect, 1'b0);
    chk("rst_write_n", avm.avm_write_n, 1'b1);
    chk("rst_busy", busy, 1'b1);
    chk("rst_valid", evt_valid, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("init_addr", avm.avm_address, 2'd2);
    chk("init_cs", avm.avm_chipselect, 1'b1);
    chk("init_write_n", avm.avm_write_n, 1'b0);
    chk("init_wdata", avm.avm_writedata, 32'hF);
    @(negedge clk);
    chk("post_init_cs", avm.avm_chipselect, 1'b0);
    chk("post_init_busy", busy, 1'b0);
    chk("mask_writes", mask_wr_cnt, 1);
    chk("pio_mask", pio_mask, 4'hF);

    // single press
    run_seq(4'h1, 4'hE, -1, -1, vr);
    chk("t1_valid_cycle", vr, H + 5);
    chk("t1_data", evt_data, 8'h1E);
    drain();

    // key 1 released before level read
    run_seq(4'h3, 4'hE, -1, -1, vr);
    chk("t2_data", evt_data, 8'h1E);
    drain();

    // spurious irq
    run_seq(4'h0, 4'hF, -1, -1, vr);
    chk("spur_valid", evt_valid, 1'b0);

    // fill and overflow
    run_seq(4'h1, 4'hE, -1, -1, vr);
    run_seq(4'h2, 4'hD, -1, -1, vr);
    run_seq(4'h4, 4'hB, -1, -1, vr);
    run_seq(4'h8, 4'h7, -1, -1, vr);
    chk("full_ovf_before", overflow, 1'b0);
    run_seq(4'hF, 4'h0, -1, -1, vr);
    chk("fifth_ovf", overflow, 1'b1);
    chk("fifth_head", evt_data, 8'h1E);

    // pop and push in the same cycle while full
    run_seq(4'h3, 4'hC, H + 4, -1, vr);
    chk("poppush_q", exp_q.size(), DEPTH);
    chk("popush_head", evt_data, 8'h2D);

    // clear with simultaneous drop
    run_seq(4'h5, 4'h0, -1, H + 4, vr);
    chk("clr_drop_ovf", overflow, 1'b1);
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    chk("clr_ovf", overflow, 1'b0);
    run_seq(4'h1, 4'h0, -1, -1, vr);

    // reset in HOLD
    m0 = mask_wr_cnt;
    pio_lvl = 4'hE;
    ec_set = 4'h1;
    @(negedge clk);
    ec_set = 4'h0;
    repeat (5) @(negedge clk);
    chk("hold_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    chk("midrst_valid", evt_valid, 1'b0);
    chk("midrst_ovf", overflow, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    @(negedge clk);
    chk("midrst_init_addr", avm.avm_address, 2'd2);
    chk("midrst_init_wr", avm.avm_write_n, 1'b0);
    repeat (20) @(negedge clk);
    chk("midrst_no_evt", evt_valid, 1'b0);
    chk("midrst_mask_wr", mask_wr_cnt, m0 + 1);
    chk("midrst_idle", busy, 1'b0);

    // randomized sequences
    for (int i = 0; i < 30; i++) begin
      rec = 4'($urandom_range(0, 15));
      rlv = 4'($urandom_range(0, 15));
      pk = (exp_q.size() != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : -1;
      ck = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1;
      run_seq(rec, rlv, pk, ck, vr);
      if ($urandom_range(0, 3) == 0) drain();
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
